// File: rtl/cpu_pkg.sv
// ============================================================================
// Module  : cpu_pkg
// Brief   : Shared widths, opcode constants and pipeline control bundle.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

  localparam int DATA_W = 16;
  localparam int REG_W  = 4;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_ADDI = 4'h3;
  localparam logic [3:0] OP_LW   = 4'h4;
  localparam logic [3:0] OP_SW   = 4'h5;
  localparam logic [3:0] OP_BEQ  = 4'h6;

  // Register addresses and write/memory controls travelling down the pipe
  typedef struct packed {
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic [REG_W-1:0] rd;
    logic             rw;
    logic             mr;
    logic             mw;
  } ctrl_t;

endpackage

`default_nettype wire

// File: rtl/hazard_detect.sv
// ============================================================================
// Module  : hazard_detect
// Brief   : Combinational load-use detection and PC / IF-ID write enables.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_detect
  import cpu_pkg::*;
#(
  parameter int REG_W_P = REG_W
) (
  input  logic               id_valid,
  input  logic [REG_W_P-1:0] id_rs,
  input  logic [REG_W_P-1:0] id_rt,
  input  logic               id_uses_rt,
  input  logic               ex_valid,
  input  logic               ex_mr,
  input  logic [REG_W_P-1:0] ex_rd,
  input  logic               br_flush,
  input  logic               mem_stall,
  output logic               lu_stall,
  output logic               pc_write,
  output logic               ifid_write
);

  logic w_rd_nz;
  logic w_rs_hit;
  logic w_rt_hit;

  // A load in EX whose destination a decode-stage source needs; r0 never stalls
  always_comb begin
    w_rd_nz  = (ex_rd != '0);
    w_rs_hit = (ex_rd == id_rs);
    w_rt_hit = id_uses_rt & (ex_rd == id_rt);
    lu_stall = id_valid & ex_valid & ex_mr & w_rd_nz & (w_rs_hit | w_rt_hit);
  end

  // Memory stall freezes the front end; a taken branch must redirect even over a load-use
  always_comb begin
    pc_write   = ~mem_stall & (br_flush | ~lu_stall);
    ifid_write = pc_write;
  end

endmodule

`default_nettype wire

// File: rtl/idex_hazard_stage.sv
// ============================================================================
// Module  : idex_hazard_stage
// Brief   : ID/EX pipeline register with load-use stall, branch flush and
//           memory-stall freeze.
// Options : HAZARD_PERF_EN adds saturating stall_cycles / flush_count outputs.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module idex_hazard_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int REG_W  = cpu_pkg::REG_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [3:0]        id_opcode,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [REG_W-1:0]  id_rd,
  input  logic              id_uses_rt,
  input  logic              id_rw,
  input  logic              id_mr,
  input  logic              id_mw,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic              br_flush,
  input  logic              mem_stall,
  output logic              ex_valid,
  output logic [3:0]        ex_opcode,
  output logic [REG_W-1:0]  ex_rs,
  output logic [REG_W-1:0]  ex_rt,
  output logic [REG_W-1:0]  ex_rd,
  output logic              ex_rw,
  output logic              ex_mr,
  output logic              ex_mw,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm,
`ifdef HAZARD_PERF_EN
  output logic [15:0]       stall_cycles,
  output logic [15:0]       flush_count,
`endif
  output logic              pc_write,
  output logic              ifid_write,
  output logic              lu_stall
);

  logic              valid_q,   valid_d;
  logic [3:0]        opcode_q,  opcode_d;
  ctrl_t             ctrl_q,    ctrl_d;
  logic [DATA_W-1:0] rs_data_q, rs_data_d;
  logic [DATA_W-1:0] rt_data_q, rt_data_d;
  logic [DATA_W-1:0] imm_q,     imm_d;

  hazard_detect #(
    .REG_W_P (REG_W)
  ) u_hazard_detect (
    .id_valid   (id_valid),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_uses_rt (id_uses_rt),
    .ex_valid   (valid_q),
    .ex_mr      (ctrl_q.mr),
    .ex_rd      (ctrl_q.rd),
    .br_flush   (br_flush),
    .mem_stall  (mem_stall),
    .lu_stall   (lu_stall),
    .pc_write   (pc_write),
    .ifid_write (ifid_write)
  );

  // Next ID/EX contents: hold on memory stall, bubble on flush/load-use, else capture
  always_comb begin
    valid_d   = valid_q;
    opcode_d  = opcode_q;
    ctrl_d    = ctrl_q;
    rs_data_d = rs_data_q;
    rt_data_d = rt_data_q;
    imm_d     = imm_q;
    if (!mem_stall) begin
      if (br_flush || lu_stall) begin
        valid_d   = 1'b0;
        opcode_d  = '0;
        ctrl_d    = '0;
        rs_data_d = '0;
        rt_data_d = '0;
        imm_d     = '0;
      end else begin
        valid_d   = id_valid;
        opcode_d  = id_opcode;
        ctrl_d.rs = id_rs;
        ctrl_d.rt = id_rt;
        ctrl_d.rd = id_rd;
        // An invalid slot must never write registers or touch memory
        ctrl_d.rw = id_valid & id_rw;
        ctrl_d.mr = id_valid & id_mr;
        ctrl_d.mw = id_valid & id_mw;
        rs_data_d = id_rs_data;
        rt_data_d = id_rt_data;
        imm_d     = id_imm;
      end
    end
  end

  // ID/EX register bank; reset leaves a bubble in EX
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      opcode_q  <= '0;
      ctrl_q    <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
    end else begin
      valid_q   <= valid_d;
      opcode_q  <= opcode_d;
      ctrl_q    <= ctrl_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      imm_q     <= imm_d;
    end
  end

  assign ex_valid   = valid_q;
  assign ex_opcode  = opcode_q;
  assign ex_rs      = ctrl_q.rs;
  assign ex_rt      = ctrl_q.rt;
  assign ex_rd      = ctrl_q.rd;
  assign ex_rw      = ctrl_q.rw;
  assign ex_mr      = ctrl_q.mr;
  assign ex_mw      = ctrl_q.mw;
  assign ex_rs_data = rs_data_q;
  assign ex_rt_data = rt_data_q;
  assign ex_imm     = imm_q;

`ifdef HAZARD_PERF_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  // Saturating counters: stalled edges and unmasked flushes
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if ((lu_stall || mem_stall) && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
    if (br_flush && !mem_stall && (flush_cnt_q != 16'hFFFF)) begin
      flush_cnt_d = flush_cnt_q + 16'd1;
    end
  end

  // Performance counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign flush_count  = flush_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_idex_hazard_stage.sv
// ============================================================================
// Module  : tb_idex_hazard_stage
// Brief   : Randomized and directed bench for idex_hazard_stage against a
//           behavioural pipeline model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_idex_hazard_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, id_uses_rt, id_rw, id_mr, id_mw;
  logic [3:0]  id_opcode, id_rs, id_rt, id_rd;
  logic [15:0] id_rs_data, id_rt_data, id_imm;
  logic        br_flush, mem_stall;
  logic        ex_valid, ex_rw, ex_mr, ex_mw;
  logic [3:0]  ex_opcode, ex_rs, ex_rt, ex_rd;
  logic [15:0] ex_rs_data, ex_rt_data, ex_imm;
  logic        pc_write, ifid_write, lu_stall;
`ifdef HAZARD_PERF_EN
  logic [15:0] stall_cycles, flush_count;
  int          m_stalls, m_flushes;
`endif

  int n_vec = 0;
  int n_err = 0;

  // Model of what EX should hold
  logic        m_valid, m_rw, m_mr, m_mw;
  logic [3:0]  m_op, m_rs, m_rt, m_rd;
  logic [15:0] m_rsd, m_rtd, m_imm;

  always #5 clk = ~clk;

  idex_hazard_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .id_valid   (id_valid),
    .id_opcode  (id_opcode),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_rd      (id_rd),
    .id_uses_rt (id_uses_rt),
    .id_rw      (id_rw),
    .id_mr      (id_mr),
    .id_mw      (id_mw),
    .id_rs_data (id_rs_data),
    .id_rt_data (id_rt_data),
    .id_imm     (id_imm),
    .br_flush   (br_flush),
    .mem_stall  (mem_stall),
    .ex_valid   (ex_valid),
    .ex_opcode  (ex_opcode),
    .ex_rs      (ex_rs),
    .ex_rt      (ex_rt),
    .ex_rd      (ex_rd),
    .ex_rw      (ex_rw),
    .ex_mr      (ex_mr),
    .ex_mw      (ex_mw),
    .ex_rs_data (ex_rs_data),
    .ex_rt_data (ex_rt_data),
    .ex_imm     (ex_imm),
`ifdef HAZARD_PERF_EN
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count),
`endif
    .pc_write   (pc_write),
    .ifid_write (ifid_write),
    .lu_stall   (lu_stall)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0;
    m_op = 0; m_rs = 0; m_rt = 0; m_rd = 0;
    m_rsd = 0; m_rtd = 0; m_imm = 0;
`ifdef HAZARD_PERF_EN
    m_stalls = 0; m_flushes = 0;
`endif
  endfunction

  task automatic check_ex();
    chk("ex_valid", 64'(ex_valid), 64'(m_valid));
    chk("ex_op",    64'(ex_opcode), 64'(m_op));
    chk("ex_regs",  64'({ex_rs, ex_rt, ex_rd}), 64'({m_rs, m_rt, m_rd}));
    chk("ex_ctrl",  64'({ex_rw, ex_mr, ex_mw}), 64'({m_rw, m_mr, m_mw}));
    chk("ex_data",  {16'h0, ex_rs_data, ex_rt_data, ex_imm}, {16'h0, m_rsd, m_rtd, m_imm});
`ifdef HAZARD_PERF_EN
    chk("stall_cycles", 64'(stall_cycles), 64'(m_stalls));
    chk("flush_count",  64'(flush_count),  64'(m_flushes));
`endif
  endtask

  // One clock: drive decode slot, check combinational hazard outputs, then the captured state
  task automatic cyc(input logic v, input logic [3:0] op, input logic [3:0] rs,
                     input logic [3:0] rt, input logic [3:0] rd, input logic urt,
                     input logic rw, input logic mr, input logic mw,
                     input logic fl, input logic ms);
    logic exp_lu, exp_pc;
    id_valid = v; id_opcode = op; id_rs = rs; id_rt = rt; id_rd = rd;
    id_uses_rt = urt; id_rw = rw; id_mr = mr; id_mw = mw;
    id_rs_data = 16'($urandom); id_rt_data = 16'($urandom); id_imm = 16'($urandom);
    br_flush = fl; mem_stall = ms;
    #1;
    exp_lu = v && m_valid && m_mr && (m_rd != 0) && ((m_rd == rs) || (urt && (m_rd == rt)));
    exp_pc = ms ? 1'b0 : (fl ? 1'b1 : !exp_lu);
    chk("lu_stall",   64'(lu_stall),   64'(exp_lu));
    chk("pc_write",   64'(pc_write),   64'(exp_pc));
    chk("ifid_write", 64'(ifid_write), 64'(exp_pc));
`ifdef HAZARD_PERF_EN
    if ((exp_lu || ms) && m_stalls < 65535) m_stalls++;
    if (fl && !ms && m_flushes < 65535) m_flushes++;
`endif
    if (!ms) begin
      if (fl || exp_lu) begin
        m_valid = 0; m_op = 0; m_rs = 0; m_rt = 0; m_rd = 0;
        m_rw = 0; m_mr = 0; m_mw = 0; m_rsd = 0; m_rtd = 0; m_imm = 0;
      end else begin
        m_valid = v; m_op = op; m_rs = rs; m_rt = rt; m_rd = rd;
        m_rw = v & rw; m_mr = v & mr; m_mw = v & mw;
        m_rsd = id_rs_data; m_rtd = id_rt_data; m_imm = id_imm;
      end
    end
    @(posedge clk);
    #1;
    check_ex();
  endtask

  initial begin
    rst_n = 0;
    id_valid = 0; id_opcode = 0; id_rs = 0; id_rt = 0; id_rd = 0;
    id_uses_rt = 0; id_rw = 0; id_mr = 0; id_mw = 0;
    id_rs_data = 0; id_rt_data = 0; id_imm = 0;
    br_flush = 0; mem_stall = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_ex();
    rst_n = 1;

    // Load-use: LW r3 then ADD r4,r3,r5 stalls once, then ADD advances
    cyc(1, 4'h4, 4'd1, 4'd0, 4'd3, 0, 1, 1, 0, 0, 0);
    cyc(1, 4'h1, 4'd3, 4'd5, 4'd4, 1, 1, 0, 0, 0, 0);
    chk("lu_bubble", 64'(ex_valid), 64'd0);
    cyc(1, 4'h1, 4'd3, 4'd5, 4'd4, 1, 1, 0, 0, 0, 0);
    chk("add_rs", 64'(ex_rs), 64'd3);

    // Load to r0 then a reader of r0: no stall
    cyc(1, 4'h4, 4'd1, 4'd0, 4'd0, 0, 1, 1, 0, 0, 0);
    cyc(1, 4'h1, 4'd0, 4'd0, 4'd4, 1, 1, 0, 0, 0, 0);
    // Load r3 then SW with rt=3 (uses_rt=0): no stall
    cyc(1, 4'h4, 4'd1, 4'd0, 4'd3, 0, 1, 1, 0, 0, 0);
    cyc(1, 4'h5, 4'd2, 4'd3, 4'd0, 0, 0, 0, 1, 0, 0);

    // Flush together with a load-use hazard
    cyc(1, 4'h4, 4'd1, 4'd0, 4'd3, 0, 1, 1, 0, 0, 0);
    cyc(1, 4'h1, 4'd3, 4'd5, 4'd4, 1, 1, 0, 0, 1, 0);
    chk("flush_bubble", 64'(ex_valid), 64'd0);

    // Memory stall held three cycles with flush asserted, then flush lands
    cyc(1, 4'h1, 4'd1, 4'd2, 4'd6, 1, 1, 0, 0, 0, 0);
    repeat (3) cyc(1, 4'h2, 4'd7, 4'd8, 4'd9, 1, 1, 0, 0, 1, 1);
    chk("held_rd", 64'(ex_rd), 64'd6);
    cyc(1, 4'h2, 4'd7, 4'd8, 4'd9, 1, 1, 0, 0, 1, 0);

    // Asynchronous reset while a load-use stall is active
    cyc(1, 4'h4, 4'd1, 4'd0, 4'd3, 0, 1, 1, 0, 0, 0);
    id_valid = 1; id_rs = 4'd3; id_uses_rt = 1; br_flush = 0; mem_stall = 0;
    #1;
    chk("pre_rst_lu", 64'(lu_stall), 64'd1);
    rst_n = 0;
    #1;
    model_reset();
    chk("rst_ex_valid", 64'(ex_valid), 64'd0);
    chk("rst_lu", 64'(lu_stall), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1;
    cyc(1, 4'h1, 4'd3, 4'd5, 4'd4, 1, 1, 0, 0, 0, 0);

    // Randomized traffic on a small register range to provoke hazards
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 9) != 0), 4'($urandom_range(0, 6)),
          4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
          1'($urandom), 1'($urandom), ($urandom_range(0, 9) < 4), 1'($urandom),
          ($urandom_range(0, 9) == 0), ($urandom_range(0, 6) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/idex_hazard_stage.md
Name: idex_hazard_stage

Overview:
- ID/EX pipeline register with integrated load-use hazard detection, branch flush and memory-stall freeze.
- Sits between decode and execute.
- Its registered rs/rt/rd and control outputs are the ID/EX-side inputs of the forwarding unit.
- Its stall outputs freeze the PC and the IF/ID register.

Parameters:
- DATA_W, 16, register-file data width
- REG_W, 4, register address width; register 0 is hardwired zero

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- id_valid  input  1  decode slot holds a real instruction
- id_opcode  input  4  decoded opcode
- id_rs  input  REG_W  source register 1
- id_rt  input  REG_W  source register 2
- id_rd  input  REG_W  destination register
- id_uses_rt  input  1  instruction reads rt in EX (0 for immediates and stores)
- id_rw  input  1  register write enable
- id_mr  input  1  memory read (load)
- id_mw  input  1  memory write (store)
- id_rs_data  input  DATA_W  register-file read data for rs
- id_rt_data  input  DATA_W  register-file read data for rt
- id_imm  input  DATA_W  sign/zero-extended immediate
- br_flush  input  1  branch resolved taken; squash the decode slot
- mem_stall  input  1  data/instruction memory busy; freeze the pipeline
- ex_valid  output  1  registered copy of id_valid
- ex_opcode  output  4  registered copy of id_opcode
- ex_rs  output  REG_W  registered copy of id_rs
- ex_rt  output  REG_W  registered copy of id_rt
- ex_rd  output  REG_W  registered copy of id_rd
- ex_rw  output  1  registered copy of id_rw
- ex_mr  output  1  registered copy of id_mr
- ex_mw  output  1  registered copy of id_mw
- ex_rs_data  output  DATA_W  registered copy of id_rs_data
- ex_rt_data  output  DATA_W  registered copy of id_rt_data
- ex_imm  output  DATA_W  registered copy of id_imm
- pc_write  output  1  0 holds the PC
- ifid_write  output  1  0 holds the IF/ID register
- lu_stall  output  1  load-use hazard detected this cycle (combinational)

Behaviour:
- Reset (async, rst_n=0): all ex_* outputs go to 0, so ex_valid=0 (bubble). This takes effect immediately, including mid-stall.
- Load-use detect (combinational): lu_stall = id_valid & ex_valid & ex_mr & (ex_rd != 0) & ((ex_rd == id_rs) | (id_uses_rt & (ex_rd == id_rt))).
- Store data is not a hazard: store data is rt with id_uses_rt=0, and MEM->MEM forwarding covers it.
- Per-edge priority:
  1. mem_stall=1: hold every ex_* register; pc_write=0, ifid_write=0. Suppresses flush and lu_stall effects for this edge.
  2. br_flush=1: load bubble (ex_valid, ex_rw, ex_mr, ex_mw cleared; other fields don't-care, loaded as 0); pc_write=1, ifid_write=1. br_flush overrides lu_stall.
  3. lu_stall=1: load bubble; pc_write=0, ifid_write=0. The decode slot re-presents the same instruction next cycle.
  4. Otherwise: capture all id_* inputs; pc_write=1, ifid_write=1.
- id_valid=0: captured as a bubble; control bits are forced to 0 regardless of id_rw/id_mr/id_mw.
- Latency: 1 cycle from decode to ex_*.
- Stall duration:
  - A load-use stall lasts exactly one cycle, because after the bubble ex_mr=0.
  - Back-to-back loads each stall independently.
- Writes to register 0 never cause a stall.
- pc_write and ifid_write are combinational from the current-cycle inputs and ex_* state.

Optional Feature:
- Macro: HAZARD_PERF_EN
- When defined, add outputs stall_cycles[15:0] and flush_count[15:0], both saturating at 16'hFFFF and reset to 0.
  - stall_cycles increments on any edge where lu_stall or mem_stall is high.
  - flush_count increments on each br_flush edge that is not masked by mem_stall.
- When undefined, these ports and registers do not exist.

Decomposition:
- Shared package cpu_pkg:
  - DATA_W and REG_W constants
  - opcode constants
  - a struct/typedef bundling rs, rt, rd, rw, mr, mw for pipeline control
- One sub-module, hazard_detect: the purely combinational lu_stall and write-enable logic.
- The register bank stays in the parent.

Test Plan:
- Reset mid-stall: hold lu_stall active, drop rst_n -> ex_valid=0 immediately; pc_write=1 on the first cycle after release.
- Load-use: LW r3 followed by ADD r4,r3,r5 -> lu_stall=1, pc_write=0, ifid_write=0 for 1 cycle, ex_valid=0 bubble; ADD captured next cycle with ex_rs=3.
- Load to r0, or load followed by SW with rt=3, id_uses_rt=0 -> no stall; the instruction advances immediately.
- br_flush together with lu_stall -> bubble inserted, pc_write=1; the squashed instruction never appears with ex_valid=1.
- mem_stall held 3 cycles while br_flush=1 -> ex_* unchanged for all 3 cycles; flush takes effect on the first cycle after mem_stall drops.
- HAZARD_PERF_EN: 2 load-use stalls + 3 mem_stall cycles + 1 flush -> stall_cycles=5, flush_count=1; a forced preload of 16'hFFFF stays saturated.
